bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (CPU m0, DMA m1) round-robin arbiter onto a single
// downstream request/response bus, one transaction in flight.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mX_valid/write/addr/wdata/wstrb   master request (held until response)
//   mX_ready/rvalid/rdata      master write-done / read-data pulses
//   bus_valid/write/addr/wdata/wstrb  downstream request (bus_valid 1 cycle)
//   bus_ready/rvalid/rdata     downstream write / read response
//   err_clr, err_sticky        sticky timeout flag and its clear
module bus_arbiter #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        err_clr,
    output logic        err_sticky
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic        win;
    logic        resp_wr, resp_rd, timeout;
    logic [31:0] rdata_sel;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        win       = 1'b0;
        bus_valid = 1'b0;
        resp_wr   = 1'b0;
        resp_rd   = 1'b0;
        timeout   = 1'b0;
        rdata_sel = bus_rdata;
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the master that did not win last time goes.
                    win     = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    grant_d = win;
                    last_d  = win;
                    wr_d    = win ? m1_write : m0_write;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    wstrb_d = win ? m1_wstrb : m0_wstrb;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus_valid = 1'b1;
                cnt_d     = 8'd0;
                state_d   = RESP;
            end
            RESP: begin
                // Only the response matching the latched direction counts.
                if (wr_q ? bus_ready : bus_rvalid) begin
                    resp_wr = wr_q;
                    resp_rd = ~wr_q;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout   = 1'b1;
                    resp_wr   = wr_q;
                    resp_rd   = ~wr_q;
                    rdata_sel = 32'hDEAD_BEEF;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A timeout in the same cycle as err_clr leaves the flag set.
        err_d = (err_q & ~err_clr) | timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign bus_write  = wr_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign bus_wstrb  = wstrb_q;
    assign err_sticky = err_q;

    assign m0_ready  = resp_wr & ~grant_q;
    assign m1_ready  = resp_wr &  grant_q;
    assign m0_rvalid = resp_rd & ~grant_q;
    assign m1_rvalid = resp_rd &  grant_q;
    assign m0_rdata  = m0_rvalid ? rdata_sel : 32'd0;
    assign m1_rdata  = m1_rvalid ? rdata_sel : 32'd0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed requests push expected bus
// requests and master responses; negedge monitors pop and compare.
module tb_bus_arbiter;

    logic        clk, rst_n;
    logic        m0_valid, m0_write, m1_valid, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_valid, bus_write, bus_ready, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        err_clr, err_sticky;

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .err_clr(err_clr), .err_sticky(err_sticky)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        m;
        logic        wr;
        logic [31:0] rdata;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          bv_log[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, bus_cyc = 0, rsp_cyc = 0;
    int          mode = 0;          // 0 correct response, 1 none, 2 wrong type
    logic [31:0] rd_val = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic push_req(input logic wr, input logic [31:0] a, d, input logic [3:0] s);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = d; r.wstrb = s;
        req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic m, input logic wr, input logic [31:0] rd);
        rsp_t r;
        r.m = m; r.wr = wr; r.rdata = wr ? 32'd0 : rd;
        rsp_q.push_back(r);
    endtask

    // Downstream model: answers one cycle after bus_valid.
    initial begin
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        forever begin
            logic w;
            @(negedge clk);
            w = bus_write;
            if (bus_valid && mode != 1) begin
                @(posedge clk); #1;
                if ((mode == 0) == w) bus_ready = 1'b1;
                else bus_rvalid = 1'b1;
                bus_rdata = rd_val;
                @(posedge clk); #1;
                bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
            end
        end
    end

    // Monitor: bus requests, master responses and output invariants.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("rdata_zero_when_idle",
                {(!m0_rvalid && m0_rdata != 0), (!m1_rvalid && m1_rdata != 0)}, 0);
            chk("single_response",
                (32'(m0_ready) + 32'(m0_rvalid) + 32'(m1_ready) + 32'(m1_rvalid)) > 1, 0);
            if (bus_valid) begin
                bus_cyc = cyc;
                bv_log.push_back(cyc);
                if (req_q.size() == 0) chk("unexpected_bus_valid", 1, 0);
                else begin
                    req_t e;
                    e = req_q.pop_front();
                    chk("bus_write", bus_write, e.wr);
                    chk("bus_addr",  bus_addr,  e.addr);
                    chk("bus_wdata", bus_wdata, e.wdata);
                    chk("bus_wstrb", bus_wstrb, e.wstrb);
                end
            end
            if (m0_ready || m0_rvalid || m1_ready || m1_rvalid) begin
                rsp_cyc = cyc;
                if (rsp_q.size() == 0) chk("unexpected_response", 1, 0);
                else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_master", m1_ready | m1_rvalid, e.m);
                    chk("rsp_is_write", m0_ready | m1_ready, e.wr);
                    chk("rsp_rdata", (m1_ready | m1_rvalid) ? m1_rdata : m0_rdata, e.rdata);
                end
            end
        end
    end

    task automatic wait_rsp(input logic m);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = m ? (m1_ready | m1_rvalid) : (m0_ready | m0_rvalid);
        end
        if (!got) chk("response_timeout", 0, 1);
    endtask

    // Single transaction from one master; called and returns at posedge+1.
    task automatic xfer(input logic m, input logic wr, input logic [31:0] a, d,
                        input logic [3:0] s, input logic [31:0] exp_rd, output int t0);
        push_req(wr, a, d, s);
        push_rsp(m, wr, exp_rd);
        if (m) begin
            m1_write = wr; m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_valid = 1'b1;
        end else begin
            m0_write = wr; m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_valid = 1'b1;
        end
        t0 = cyc;
        wait_rsp(m);
        @(posedge clk); #1;
        if (m) m1_valid = 1'b0;
        else m0_valid = 1'b0;
    endtask

    initial begin
        int t0, rel, base;
        rst_n = 1'b0; err_clr = 1'b0;
        m0_valid = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb, err_sticky,
             m0_ready, m0_rvalid, m1_ready, m1_rvalid}, 0);
        chk("reset_rdata", {m0_rdata, m1_rdata}, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // CPU write: bus_valid one cycle after sampling, ready one after that.
        xfer(1'b0, 1'b1, 32'h0001_0004, 32'hA5A5_A5A5, 4'hF, 32'd0, t0);
        chk("wr_bus_latency", bus_cyc - t0, 1);
        chk("wr_rsp_latency", rsp_cyc - t0, 2);

        // DMA read returning data.
        rd_val = 32'h1234_5678;
        xfer(1'b1, 1'b0, 32'h0002_0010, 32'd0, 4'h0, 32'h1234_5678, t0);
        chk("rd_rsp_latency", rsp_cyc - t0, 2);

        // Both masters valid from reset: m0, m1, m0, m1 at 3-cycle spacing.
        rst_n = 1'b0;
        rd_val = 32'hCAFE_0001;
        m0_write = 1; m0_addr = 32'h0000_00A0; m0_wdata = 32'h1111_1111; m0_wstrb = 4'h3;
        m1_write = 0; m1_addr = 32'h0000_00B0; m1_wdata = 32'h0;         m1_wstrb = 4'h0;
        m0_valid = 1; m1_valid = 1;
        push_req(1, 32'h0000_00A0, 32'h1111_1111, 4'h3); push_rsp(0, 1, 0);
        push_req(0, 32'h0000_00B0, 32'h0,         4'h0); push_rsp(1, 0, 32'hCAFE_0001);
        push_req(1, 32'h0000_00A4, 32'h2222_2222, 4'hC); push_rsp(0, 1, 0);
        push_req(0, 32'h0000_00B4, 32'h0,         4'h0); push_rsp(1, 0, 32'hCAFE_0001);
        base = bv_log.size();
        @(posedge clk); #1; rst_n = 1'b1;
        fork
            begin
                wait_rsp(0); @(posedge clk); #1;
                m0_addr = 32'h0000_00A4; m0_wdata = 32'h2222_2222; m0_wstrb = 4'hC;
                wait_rsp(0); @(posedge clk); #1; m0_valid = 0;
            end
            begin
                wait_rsp(1); @(posedge clk); #1;
                m1_addr = 32'h0000_00B4;
                wait_rsp(1); @(posedge clk); #1; m1_valid = 0;
            end
        join
        chk("rr_bus_count", bv_log.size() - base, 4);
        if (bv_log.size() - base == 4)
            for (int i = 1; i < 4; i++)
                chk("rr_bus_spacing", bv_log[base + i] - bv_log[base + i - 1], 3);

        // Read timeout: error data on the 4th RESP cycle, sticky flag set.
        mode = 1;
        xfer(1'b0, 1'b0, 32'h0000_0300, 32'd0, 4'h0, 32'hDEAD_BEEF, t0);
        chk("rd_timeout_latency", rsp_cyc - t0, 5);
        chk("err_set_rd_timeout", err_sticky, 1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        chk("err_cleared", err_sticky, 0);

        // Write answered with rvalid: ignored, times out.
        mode = 2;
        xfer(1'b0, 1'b1, 32'h0000_0400, 32'h5A5A_0000, 4'h1, 32'd0, t0);
        chk("wrong_type_latency", rsp_cyc - t0, 5);
        chk("err_set_wrong_type", err_sticky, 1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        chk("err_cleared_2", err_sticky, 0);

        // err_clr held through a timeout: the set wins.
        mode = 1;
        err_clr = 1'b1;
        xfer(1'b1, 1'b1, 32'h0000_0500, 32'h0000_0055, 4'h2, 32'd0, t0);
        chk("err_set_beats_clear", err_sticky, 1);
        err_clr = 1'b0;
        @(posedge clk); #1;
        chk("err_holds", err_sticky, 1);

        // Reset during RESP: no response, request reissued after release.
        push_req(0, 32'h0000_0600, 32'd0, 4'h0);
        push_req(0, 32'h0000_0600, 32'd0, 4'h0);
        push_rsp(0, 0, 32'h0BAD_F00D);
        m0_write = 0; m0_addr = 32'h0000_0600; m0_wdata = 0; m0_wstrb = 0; m0_valid = 1;
        for (int i = 0; i < 10 && !bus_valid; i++) @(negedge clk);
        chk("pre_reset_issue", bus_valid, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_bus", {bus_valid, bus_write, bus_addr}, 0);
        chk("reset_async_err", err_sticky, 0);
        chk("reset_async_rsp", {m0_ready, m0_rvalid, m0_rdata}, 0);
        mode = 0; rd_val = 32'h0BAD_F00D;
        @(posedge clk); #1; rst_n = 1'b1; rel = cyc;
        wait_rsp(0);
        chk("reissue_latency", bus_cyc - rel, 1);
        @(posedge clk); #1; m0_valid = 0;

        repeat (4) @(posedge clk);
        chk("req_queue_drained", req_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
